// File: rtl/busy_timer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// busy_arb_pkg
// Shared types and defaults for busy_timer_arbiter and its round-robin picker.
//   state_t          : arbiter state (IDLE when the timer is zero, BUSY otherwise)
//   *_DEF constants  : default parameter values for the top module
//   next_ptr(idx, n) : round-robin successor, (idx + 1) mod n
// -----------------------------------------------------------------------------
package busy_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int         N_REQ_DEF       = 4;
    localparam int         CNT_W_DEF       = 4;
    localparam logic [3:0] DEFAULT_LEN_DEF = 4'hA;
    localparam int         MAX_WAIT_DEF    = 64;

    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/busy_timer_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Scans valid starting at rr_ptr, wrapping
// modulo N_REQ, and selects the first set bit.
//   valid     in  N_REQ  request vector
//   rr_ptr    in  IDX_W  highest-priority index for this scan
//   grant     out N_REQ  one-hot winner (all zero when nothing is valid)
//   winner    out IDX_W  index of the winner (0 when nothing is valid)
//   any_valid out 1      at least one request is valid
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[IDX_W-1:0];
            // First hit in scan order wins; later hits are ignored.
            if (!any_valid && valid[idx]) begin
                any_valid   = 1'b1;
                winner      = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/busy_timer_arbiter.sv
// -----------------------------------------------------------------------------
// busy_timer_arbiter
// Shares one countdown busy-timer among N_REQ requesters with round-robin
// arbitration. An accepted request loads the timer with its length (or
// DEFAULT_LEN for length 0); the timer counts down to zero, and only while it
// is zero can the next grant be issued. owner_id tells the datapath who owns
// the shared resource.
//
// Handshake: requester i is accepted in a cycle where req_valid[i] and
// req_ready[i] are both high. req_valid must stay high and req_len stable until
// acceptance; req_ready is combinational from req_valid and at most one bit high.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    in  N_REQ        per-requester request
//   req_len      in  N_REQ*CNT_W  per-requester length, slice i = [i*CNT_W +: CNT_W]
//   req_ready    out N_REQ        one-hot acceptance
//   grant_valid  out 1            one-cycle pulse the cycle after acceptance
//   owner_id     out IDX_W        current/last owner of the timer
//   busy         out 1            timer nonzero (the FSM state, registered)
//   count_out    out CNT_W        current timer value
//   starve_err   out N_REQ        sticky wait-limit flags
//
// Optional feature: define BUSY_ARB_WAIT_MON_EN to build the per-requester wait
// monitor; otherwise starve_err is tied to zero.
// -----------------------------------------------------------------------------
module busy_timer_arbiter
    import busy_arb_pkg::*;
#(
    parameter int               N_REQ       = N_REQ_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_LEN = CNT_W'(DEFAULT_LEN_DEF),
    parameter int               MAX_WAIT    = MAX_WAIT_DEF,
    localparam int              IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       owner_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       count_out,
    output logic [N_REQ-1:0]       starve_err
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             grant_q, grant_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic [CNT_W-1:0] win_len;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid     (req_valid),
        .rr_ptr    (ptr_q),
        .grant     (pick_onehot),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    // State register: timer, owner, round-robin pointer, grant pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Length of the winning requester, muxed by the one-hot grant.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                win_len = req_len[i*CNT_W +: CNT_W];
            end
        end
    end

    assign accept = |req_ready;

    // Next-state logic. Acceptance only happens in IDLE (count zero), so the
    // load and the decrement never compete; the decrement stops at zero.
    always_comb begin
        count_d = count_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = 1'b0;
        if (accept) begin
            count_d = (win_len == '0) ? DEFAULT_LEN : win_len;
            owner_d = pick_idx;
            ptr_d   = IDX_W'(next_ptr(32'(pick_idx), N_REQ));
            grant_d = 1'b1;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
        state_d = (count_d != '0) ? BUSY : IDLE;
    end

    // Output logic. Ready is held low during reset so nothing is accepted
    // while the registers are being cleared.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && pick_any) begin
            req_ready = pick_onehot;
        end
    end

    assign grant_valid = grant_q;
    assign owner_id    = owner_q;
    assign busy        = (state_q == BUSY);
    assign count_out   = count_q;

`ifdef BUSY_ARB_WAIT_MON_EN
    localparam int               WAIT_W   = $clog2(MAX_WAIT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q [N_REQ];
    logic [N_REQ-1:0]  starve_q;

    // The flag is set on the same edge the counter reaches WAIT_LIM, so it is
    // visible together with the saturated count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    wait_cnt_q[i] <= '0;
                end else if (req_valid[i]) begin
                    if (wait_cnt_q[i] != WAIT_LIM) begin
                        wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
                    end
                    if (wait_cnt_q[i] >= WAIT_LIM - 1'b1) begin
                        starve_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign starve_err = starve_q;
`else
    assign starve_err = '0;
`endif

endmodule

// File: tb/tb_busy_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_busy_timer_arbiter
// Directed bench for busy_timer_arbiter (N_REQ=4, CNT_W=4, DEFAULT_LEN=4'hA,
// MAX_WAIT=8). Expected grants {owner_id, count_out} are queued when a request
// is driven; a monitor pops one entry each cycle grant_valid is high.
// Inputs change 2 time units after a rising edge; combinational outputs are
// checked 1 unit later, registered outputs at the falling edge.
// -----------------------------------------------------------------------------
module tb_busy_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = 2;
    localparam int W  = IW + CW;

`ifdef BUSY_ARB_WAIT_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*CW-1:0] req_len = '0;
    logic [N-1:0]  req_ready;
    logic          grant_valid;
    logic [IW-1:0] owner_id;
    logic          busy;
    logic [CW-1:0] count_out;
    logic [N-1:0]  starve_err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    busy_timer_arbiter #(
        .N_REQ       (N),
        .CNT_W       (CW),
        .DEFAULT_LEN (4'hA),
        .MAX_WAIT    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .owner_id    (owner_id),
        .busy        (busy),
        .count_out   (count_out),
        .starve_err  (starve_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_len(input int i, input logic [CW-1:0] v);
        req_len[i*CW +: CW] = v;
    endtask

    task automatic expect_grant(input int w, input logic [CW-1:0] ld);
        exp_q.push_back({IW'(w), ld});
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (grant_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got owner %0d count %0h, expected no grant",
                             owner_id, count_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_owner_count", {26'd0, owner_id, count_out}, {26'd0, e});
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset with every requester asking: nothing may be accepted.
        rst = 1'b1;
        req_valid = 4'b1111;
        repeat (3) step();
        settle();
        chk("rst_ready", req_ready, 0);
        chk("rst_count", count_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner_id, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_starve", starve_err, 0);
        req_valid = '0;
        step();
        rst = 1'b0;
        step();
        settle();
        chk("idle_no_req_ready", req_ready, 0);

        // Single request from 0, length 3.
        set_len(0, 4'd3);
        req_valid = 4'b0001;
        settle();
        chk("t1_ready", req_ready, 4'b0001);
        expect_grant(0, 4'd3);
        step();
        req_valid = '0;
        settle();
        chk("t1_count3", count_out, 3);
        chk("t1_busy3", busy, 1);
        chk("t1_ready_busy", req_ready, 0);
        for (int v = 2; v >= 1; v--) begin
            step();
            settle();
            chk("t1_count", count_out, v);
            chk("t1_busy", busy, 1);
        end
        step();
        settle();
        chk("t1_count0", count_out, 0);
        chk("t1_idle", busy, 0);

        // Grant in the same cycle the timer hits 0; length 0 loads DEFAULT_LEN.
        set_len(2, 4'd0);
        req_valid = 4'b0100;
        settle();
        chk("t2_ready", req_ready, 4'b0100);
        expect_grant(2, 4'hA);
        step();
        req_valid = '0;
        settle();
        chk("t2_count_default", count_out, 4'hA);
        for (int v = 9; v >= 1; v--) begin
            step();
            settle();
            chk("t2_count", count_out, v);
        end
        step();
        settle();
        chk("t2_count0", count_out, 0);
        chk("t2_idle", busy, 0);

        // Reset while busy at count 5 (pointer is 2 at that point).
        set_len(1, 4'd7);
        req_valid = 4'b0010;
        settle();
        chk("t5_ready", req_ready, 4'b0010);
        expect_grant(1, 4'd7);
        step();
        req_valid = '0;
        settle();
        chk("t5_count7", count_out, 7);
        step();
        step();
        settle();
        chk("t5_count5", count_out, 5);
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_len(i, 4'd1);
        settle();
        chk("t5_ready_in_rst", req_ready, 0);
        step();
        settle();
        chk("t5_count_cleared", count_out, 0);
        chk("t5_busy_cleared", busy, 0);
        chk("t5_ready_in_rst2", req_ready, 0);
        step();
        rst = 1'b0;
        settle();

        // All four valid, length 1: 0,1,2,3,0 every 2 cycles (pointer back at 0).
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready_onehot", req_ready, 4'b0001 << (i % 4));
            expect_grant(i % 4, 4'd1);
            step();
            if (i == 4) req_valid = '0;
            settle();
            chk("t3_ready_busy", req_ready, 0);
            chk("t3_count1", count_out, 1);
            step();
            settle();
            chk("t3_count0", count_out, 0);
        end
        chk("t3_ready_none", req_ready, 0);

        // Move pointer to 2, then 0 and 3 compete: 3 wins, then 0.
        set_len(1, 4'd1);
        req_valid = 4'b0010;
        settle();
        chk("t4_ready_r1", req_ready, 4'b0010);
        expect_grant(1, 4'd1);
        step();
        req_valid = '0;
        settle();
        step();
        settle();
        chk("t4_idle", count_out, 0);
        set_len(0, 4'd2);
        set_len(3, 4'd5);
        req_valid = 4'b1001;
        settle();
        chk("t4_ready_r3", req_ready, 4'b1000);
        expect_grant(3, 4'd5);
        step();
        req_valid = 4'b0001;
        settle();
        chk("t4_ready_busy", req_ready, 0);
        chk("t4_count5", count_out, 5);
        repeat (4) step();
        settle();
        chk("t4_count1", count_out, 1);
        chk("t4_ready_busy2", req_ready, 0);
        step();
        settle();
        chk("t4_ready_r0", req_ready, 4'b0001);
        expect_grant(0, 4'd2);
        step();
        req_valid = '0;
        settle();
        step();
        step();
        settle();
        chk("t4_idle2", count_out, 0);

        // Requester 1 waits behind a length-15 grant to requester 0.
        set_len(0, 4'hF);
        req_valid = 4'b0001;
        settle();
        chk("t6_ready_r0", req_ready, 4'b0001);
        expect_grant(0, 4'hF);
        step();
        set_len(1, 4'd4);
        req_valid = 4'b0010;
        settle();
        chk("t6_count15", count_out, 4'hF);
        chk("t6_starve_early", starve_err, 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            settle();
            chk("t6_starve_before_limit", starve_err, 0);
        end
        step();
        settle();
        chk("t6_starve_at_limit", starve_err, MON ? 4'b0010 : 4'b0000);
        chk("t6_count7", count_out, 7);
        repeat (7) step();
        settle();
        chk("t6_count0", count_out, 0);
        chk("t6_ready_r1", req_ready, 4'b0010);
        expect_grant(1, 4'd4);
        step();
        req_valid = '0;
        settle();
        chk("t6_starve_sticky", starve_err, MON ? 4'b0010 : 4'b0000);
        chk("t6_count4", count_out, 4);
        step();
        rst = 1'b1;
        step();
        settle();
        chk("t6_starve_rst", starve_err, 0);
        chk("t6_count_rst", count_out, 0);
        rst = 1'b0;

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
